// File: rtl/egd_stream_ctrl.sv
// rtl/egd_stream_ctrl.sv - exp-Golomb decoder stream sequencer; optional perf counters under EGD_STREAM_CTRL_PERF_EN
module egd_stream_ctrl #(
  parameter int MAX_WAIT = 15
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        word_valid,
  input  logic [15:0] word_data,
  output logic        word_ready,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_sel,
  output logic        cmd_ready,
  output logic [15:0] egd_window,
  output logic [1:0]  egd_sel,
  output logic        egd_start,
  input  logic        egd_done,
  input  logic [4:0]  egd_len,
  input  logic [7:0]  egd_value,
  output logic        res_valid,
  output logic [7:0]  res_data,
  input  logic        res_ready,
  output logic [5:0]  fill_level,
  output logic [1:0]  err
`ifdef EGD_STREAM_CTRL_PERF_EN
  ,
  output logic [15:0] perf_decodes,
  output logic [15:0] perf_stalls
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Timeout fires on the last of MAX_WAIT waiting cycles.
  localparam logic [3:0] LP_WAIT_LAST = 4'(MAX_WAIT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_window;
  logic [5:0]  r_fill;
  logic [1:0]  r_sel;
  logic [3:0]  r_wait;
  logic        r_res_valid;
  logic [7:0]  r_res_data;
  logic [1:0]  r_err;

  logic        w_word_ready;
  logic        w_cmd_ready;
  logic        w_start;
  logic        w_done_take;
  logic        w_timeout;
  logic        w_word_take;
  logic        w_cmd_take;
  logic        w_len_bad;
  logic [4:0]  w_shamt;
  logic [31:0] w_ins;
  logic [31:0] w_keep;

  assign w_word_take = word_valid & w_word_ready;
  assign w_cmd_take  = cmd_valid & w_cmd_ready;

  // New word lands just below the valid bits; bits at and below the fill point are replaced.
  assign w_ins  = {word_data, 16'h0000} >> r_fill;
  assign w_keep = ~(32'hFFFF_FFFF >> r_fill);

  // Clamp the decoder's consumed length into 0..16 and flag out-of-range values.
  always_comb begin
    w_len_bad = 1'b0;
    w_shamt   = egd_len;
    if (egd_len == 5'd0) begin
      w_len_bad = 1'b1;
      w_shamt   = 5'd0;
    end else if (egd_len > 5'd16) begin
      w_len_bad = 1'b1;
      w_shamt   = 5'd16;
    end
  end

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_word_ready = 1'b0;
    w_cmd_ready  = 1'b0;
    w_start      = 1'b0;
    w_done_take  = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_word_ready = (r_fill <= 6'd16);
        w_cmd_ready  = (r_fill >= 6'd16) && !r_res_valid;
        if (cmd_valid && w_cmd_ready) w_state_nxt = ST_ISSUE;
        else if (r_fill < 6'd16)      w_state_nxt = ST_FILL;
      end
      ST_FILL: begin
        w_word_ready = (r_fill <= 6'd16);
        if (r_fill >= 6'd16) w_state_nxt = ST_IDLE;
      end
      ST_ISSUE: begin
        w_start     = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (egd_done) begin
          w_done_take = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (r_wait == LP_WAIT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Window and fill level: consume on decode completion, append on word accept.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_window <= 32'h0;
      r_fill   <= 6'd0;
    end else if (w_done_take) begin
      r_window <= r_window << w_shamt;
      r_fill   <= r_fill - {1'b0, w_shamt};
    end else if (w_word_take) begin
      r_window <= (r_window & w_keep) | w_ins;
      r_fill   <= r_fill + 6'd16;
    end
  end

  // Mode latch and decoder wait counter.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_sel  <= 2'd0;
      r_wait <= 4'd0;
    end else begin
      if (w_cmd_take) r_sel <= cmd_sel;
      if (r_state == ST_ISSUE)                r_wait <= 4'd0;
      else if (r_state == ST_WAIT && !egd_done) r_wait <= r_wait + 4'd1;
    end
  end

  // Result holding register; the decode result is captured as the decoder reports done.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_res_valid <= 1'b0;
      r_res_data  <= 8'h00;
    end else if (w_done_take) begin
      r_res_valid <= 1'b1;
      r_res_data  <= egd_value;
    end else if (r_res_valid && res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_err <= 2'b00;
    end else begin
      if (w_timeout)               r_err[0] <= 1'b1;
      if (w_done_take && w_len_bad) r_err[1] <= 1'b1;
    end
  end

`ifdef EGD_STREAM_CTRL_PERF_EN
  logic [15:0] r_perf_decodes;
  logic [15:0] r_perf_stalls;
  logic        w_stall;

  assign w_stall = (r_state == ST_FILL) ||
                   ((r_state == ST_IDLE) && cmd_valid && !w_cmd_ready);

  // Saturating decode and stall counters.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_perf_decodes <= 16'h0000;
      r_perf_stalls  <= 16'h0000;
    end else begin
      if (r_state == ST_DONE && r_perf_decodes != 16'hFFFF) r_perf_decodes <= r_perf_decodes + 16'd1;
      if (w_stall && r_perf_stalls != 16'hFFFF)             r_perf_stalls  <= r_perf_stalls + 16'd1;
    end
  end

  assign perf_decodes = r_perf_decodes;
  assign perf_stalls  = r_perf_stalls;
`endif

  assign word_ready = w_word_ready;
  assign cmd_ready  = w_cmd_ready;
  assign egd_start  = w_start;
  assign egd_window = r_window[31:16];
  assign egd_sel    = r_sel;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign fill_level = r_fill;
  assign err        = r_err;

endmodule
